// File: rtl/intersection_timer.sv
// Master countdown for a two-way intersection: alternates NS and EW green phases
// separated by all-red clearance, with pedestrian-request shortening.
module intersection_timer #(
  parameter int unsigned TICK_DIV   = 50,
  parameter int unsigned GREEN_TIME = 120,
  parameter int unsigned PED_TIME   = 30,
  parameter int unsigned CLEAR_TIME = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       ped_req,
  output logic [6:0] master_timer,
  output logic       ns_enable,
  output logic       ew_enable,
  output logic [1:0] phase
);

  localparam int unsigned PW = $clog2(TICK_DIV);
  localparam int unsigned CW = $clog2(CLEAR_TIME + 1);

  typedef enum logic [2:0] {
    StIdle,
    StNs,
    StClearNs,
    StEw,
    StClearEw
  } state_e;

  state_e          r_state, w_state_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic [6:0]      r_timer, w_timer_nxt;
  logic [CW-1:0]   r_clr, w_clr_nxt;
  logic            r_ped, w_ped_nxt;
  logic            w_tick;

  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_presc <= '0;
      r_timer <= '0;
      r_clr   <= '0;
      r_ped   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_presc_nxt;
      r_timer <= w_timer_nxt;
      r_clr   <= w_clr_nxt;
      r_ped   <= w_ped_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_presc_nxt = w_tick ? '0 : r_presc + PW'(1);
    w_timer_nxt = r_timer;
    w_clr_nxt   = r_clr;
    w_ped_nxt   = r_ped | ped_req;

    if (!run) begin
      w_state_nxt = StIdle;
      w_presc_nxt = '0;
      w_timer_nxt = '0;
      w_clr_nxt   = '0;
      w_ped_nxt   = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_state_nxt = StNs;
          w_timer_nxt = 7'(GREEN_TIME);
        end
        StNs, StEw: begin
          if (w_tick) begin
            if (r_timer == 7'd0) begin
              w_state_nxt = (r_state == StNs) ? StClearNs : StClearEw;
            end else if (r_ped && (r_timer > 7'(PED_TIME))) begin
              // Request consumed; a fresh request in the same cycle re-arms it.
              w_timer_nxt = 7'(PED_TIME);
              w_ped_nxt   = ped_req;
            end else begin
              w_timer_nxt = r_timer - 7'd1;
            end
          end
        end
        StClearNs, StClearEw: begin
          w_timer_nxt = '0;
          if (w_tick) begin
            if (r_clr == CW'(CLEAR_TIME - 1)) begin
              w_state_nxt = (r_state == StClearNs) ? StEw : StNs;
              w_timer_nxt = 7'(GREEN_TIME);
            end else begin
              w_clr_nxt = r_clr + CW'(1);
            end
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_timer_nxt = '0;
        end
      endcase

      if (w_state_nxt != r_state) begin
        w_presc_nxt = '0;
        w_clr_nxt   = '0;
        if (w_state_nxt == StClearNs || w_state_nxt == StClearEw || w_state_nxt == StIdle) begin
          w_ped_nxt = 1'b0;
        end
      end
    end
  end

  always_comb begin
    master_timer = r_timer;
    ns_enable    = (r_state == StNs);
    ew_enable    = (r_state == StEw);
    unique case (r_state)
      StNs:                 phase = 2'd1;
      StEw:                 phase = 2'd2;
      StClearNs, StClearEw: phase = 2'd3;
      default:              phase = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_intersection_timer.sv
// Bench for intersection_timer: directed vector table, corner sequences and a
// randomized run against a phase-level reference model.
module tb_intersection_timer;

  localparam int TD = 4;
  localparam int GT = 120;
  localparam int PT = 30;
  localparam int CT = 3;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       ped_req;
  logic [6:0] master_timer;
  logic       ns_enable;
  logic       ew_enable;
  logic [1:0] phase;

  int n_checks = 0;
  int n_errors = 0;

  intersection_timer #(
    .TICK_DIV  (TD),
    .GREEN_TIME(GT),
    .PED_TIME  (PT),
    .CLEAR_TIME(CT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .ped_req     (ped_req),
    .master_timer(master_timer),
    .ns_enable   (ns_enable),
    .ew_enable   (ew_enable),
    .phase       (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic  r;
    logic  p;
    int    cycles;
    int    ph;
    int    tm;
    logic  ns;
    logic  ew;
    string name;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic r, logic p, int c, int ph, int tm, logic ns, logic ew,
                              string name);
    vec_t v;
    v.r = r; v.p = p; v.cycles = c; v.ph = ph; v.tm = tm; v.ns = ns; v.ew = ew; v.name = name;
    return v;
  endfunction

  task automatic chk(string name, int ph, int tm, logic ns, logic ew);
    n_checks++;
    if (int'(phase) != ph || int'(master_timer) != tm || ns_enable !== ns || ew_enable !== ew)
    begin
      n_errors++;
      if (n_errors <= 30)
        $display("FAIL %s: got phase=%0d timer=%0d ns=%0b ew=%0b, want phase=%0d timer=%0d ns=%0b ew=%0b",
                 name, phase, master_timer, ns_enable, ew_enable, ph, tm, ns, ew);
    end
  endtask

  task automatic cyc(logic r, logic p);
    run     = r;
    ped_req = p;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    run     = 1'b0;
    ped_req = 1'b0;
    rst_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model: phases 0 idle, 1 NS green, 2 NS clearance, 3 EW green, 4 EW clearance.
  int m_ph, m_tm, m_age, m_clr;
  bit m_ped;

  function automatic void m_enter(int ph);
    m_ph  = ph;
    m_age = 0;
    m_clr = 0;
    m_tm  = (ph == 1 || ph == 3) ? GT : 0;
    if (ph == 0 || ph == 2 || ph == 4) m_ped = 0;
  endfunction

  function automatic void m_reset();
    m_ph = 0; m_tm = 0; m_age = 0; m_clr = 0; m_ped = 0;
  endfunction

  function automatic void m_step(logic r, logic p);
    bit tick;
    bit old_ped;
    if (!r) begin
      m_reset();
      return;
    end
    tick    = ((m_age % TD) == TD - 1);
    old_ped = m_ped;
    m_ped   = m_ped | p;
    if (m_ph == 0) begin
      m_enter(1);
    end else if (m_ph == 1 || m_ph == 3) begin
      if (tick && m_tm == 0) begin
        m_enter(m_ph + 1);
        return;
      end
      if (tick && old_ped && m_tm > PT) begin
        m_tm  = PT;
        m_ped = p;
      end else if (tick) begin
        m_tm = m_tm - 1;
      end
      m_age++;
    end else begin
      if (tick) m_clr++;
      if (m_clr == CT) m_enter(m_ph == 2 ? 3 : 1);
      else m_age++;
    end
  endfunction

  function automatic int m_phase_code();
    case (m_ph)
      1: return 1;
      3: return 2;
      2, 4: return 3;
      default: return 0;
    endcase
  endfunction

  initial begin
    tbl[0]  = mk(1, 0, 1,   1, 120, 1, 0, "ns_entry");
    tbl[1]  = mk(1, 0, 4,   1, 119, 1, 0, "first_tick");
    tbl[2]  = mk(1, 0, 476, 1, 0,   1, 0, "ns_zero");
    tbl[3]  = mk(1, 0, 3,   1, 0,   1, 0, "zero_hold");
    tbl[4]  = mk(1, 0, 1,   3, 0,   0, 0, "clear_ns_entry");
    tbl[5]  = mk(1, 0, 11,  3, 0,   0, 0, "clear_ns_hold");
    tbl[6]  = mk(1, 0, 1,   2, 120, 0, 1, "ew_entry");
    tbl[7]  = mk(1, 0, 252, 2, 57,  0, 1, "ew_57");
    tbl[8]  = mk(0, 0, 1,   0, 0,   0, 0, "run_drop");
    tbl[9]  = mk(1, 0, 1,   1, 120, 1, 0, "ns_reentry");
    tbl[10] = mk(1, 0, 80,  1, 100, 1, 0, "ns_100");
    tbl[11] = mk(1, 1, 1,   1, 100, 1, 0, "ped_at_100");
    tbl[12] = mk(1, 0, 3,   1, 30,  1, 0, "ped_shorten");
    tbl[13] = mk(1, 0, 4,   1, 29,  1, 0, "after_shorten");
    tbl[14] = mk(1, 0, 36,  1, 20,  1, 0, "ns_20");
    tbl[15] = mk(1, 1, 1,   1, 20,  1, 0, "ped_at_20");
    tbl[16] = mk(1, 0, 3,   1, 19,  1, 0, "ped_no_effect");
    tbl[17] = mk(1, 0, 76,  1, 0,   1, 0, "ns_zero2");
    tbl[18] = mk(1, 0, 4,   3, 0,   0, 0, "clear_ns2");
    tbl[19] = mk(1, 0, 11,  3, 0,   0, 0, "clear_ns2_hold");
    tbl[20] = mk(1, 0, 1,   2, 120, 0, 1, "ew_entry2");
    tbl[21] = mk(1, 0, 4,   2, 119, 0, 1, "flag_cleared");
    tbl[22] = mk(1, 0, 3,   2, 119, 0, 1, "pre_tick");

    rst_n   = 1'b1;
    run     = 1'b0;
    ped_req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_async", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc(0, 0);
      chk("idle_run0", 0, 0, 0, 0);
    end

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].cycles; c++) cyc(tbl[i].r, tbl[i].p);
      chk(tbl[i].name, tbl[i].ph, tbl[i].tm, tbl[i].ns, tbl[i].ew);
    end

    // ped_req coincident with a tick: normal decrement now, shortening on the next tick.
    cyc(1, 1);
    chk("ped_with_tick", 2, 118, 0, 1);
    repeat (4) cyc(1, 0);
    chk("ped_next_tick", 2, 30, 0, 1);

    // Asynchronous reset between edges during NS clearance.
    do_reset();
    cyc(1, 0);
    chk("ns_after_reset", 1, 120, 1, 0);
    repeat (484) cyc(1, 0);
    chk("clear_before_rst", 3, 0, 0, 0);
    repeat (2) cyc(1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_clear", 0, 0, 0, 0);
    run = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0);
      chk("no_resume", 0, 0, 0, 0);
    end
    cyc(1, 0);
    chk("restart_ns", 1, 120, 1, 0);

    // Randomized run against the reference model.
    do_reset();
    m_reset();
    for (int i = 0; i < 8000; i++) begin
      logic r, p;
      r = ($urandom_range(0, 299) != 0);
      p = ($urandom_range(0, 39) == 0);
      cyc(r, p);
      m_step(r, p);
      chk("random", m_phase_code(), m_tm, m_ph == 1, m_ph == 3);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
